handshake_sink: RTL
===================

HANDSHAKE_SINK -- requirements
Module: handshake_sink

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset; takes priority over every other input.
REQ-004 valid_i  input  1  beat offered by the upstream stage.
REQ-005 data_i  input  8  beat payload.
REQ-006 ready_o  output  1  sink accepts a beat this cycle.
REQ-007 cfg_load_i  input  1  one-cycle pulse that loads configuration and starts or restarts checking.
REQ-008 cfg_pattern_i  input  8  backpressure pattern; bit n = ready in pattern slot n.
REQ-009 cfg_start_i  input  8  first expected data value.
REQ-010 beat_cnt_o  output  16  accepted beats since the last load.
REQ-011 err_cnt_o  output  8  data mismatches since the last load.
REQ-012 err_o  output  1  one-cycle pulse in the cycle after a mismatching beat.
REQ-013 proto_err_o  output  1  sticky flag for an upstream handshake-rule violation.
REQ-014 last_data_o  output  8  payload of the most recent accepted beat.

Function
REQ-015 The state machine SHALL have two states: IDLE (reset state) and RUN.
REQ-016 IDLE->RUN SHALL occur on cfg_load_i; RUN SHALL persist until rst, and cfg_load_i in RUN SHALL restart RUN.
REQ-017 On cfg_load_i the module SHALL load:
  - pat_q <= cfg_pattern_i
  - exp_q <= cfg_start_i
  - beat_cnt_o <= 0 and err_cnt_o <= 0
  - proto_err_o <= 0
REQ-018 ready_o SHALL equal (state==RUN) && pat_q[0], decoded from registers only, with no combinational path from any input.
REQ-019 In RUN, pat_q SHALL rotate right by one bit every cycle (bit0 -> bit7), independent of valid_i.
REQ-020 A transfer SHALL occur in a cycle where valid_i && ready_o.
REQ-021 On each transfer the module SHALL:
  - increment beat_cnt_o (wraps 0xFFFF->0x0000)
  - set last_data_o <= data_i
  - compare data_i with exp_q
REQ-022 On a match, exp_q SHALL become exp_q+1 mod 256 (0xFF->0x00).
REQ-023 On a mismatch the module SHALL:
  - increment err_cnt_o, saturating at 0xFF
  - pulse err_o high for exactly the next cycle
  - resynchronise with exp_q <= data_i+1 mod 256
REQ-024 If cfg_load_i coincides with a transfer, the load SHALL win; that beat is handshaken but not counted, checked, or stored.
REQ-025 The protocol monitor SHALL register hold_q = valid_i && !ready_o and hold_data_q = data_i every cycle in RUN.
REQ-026 If hold_q is set and, in the following cycle, valid_i==0 or data_i!=hold_data_q, proto_err_o SHALL set and stay set until rst or cfg_load_i.
REQ-027 A protocol violation SHALL NOT alter beat_cnt_o, err_cnt_o or exp_q.
REQ-028 In IDLE, ready_o SHALL be 0, valid_i SHALL be ignored, and the protocol monitor SHALL be disabled.
REQ-029 A pattern of 0x00 SHALL hold ready_o low permanently; 0xFF SHALL hold it high every RUN cycle.

Reset
REQ-030 On rst the module SHALL set:
  - state = IDLE
  - ready_o = 0
  - pat_q, exp_q, beat_cnt_o, err_cnt_o, last_data_o = 0
  - err_o, proto_err_o, hold_q = 0
REQ-031 rst asserted mid-stream SHALL take effect at the next edge, discard any beat offered in that cycle, and require a new cfg_load_i to resume.

Verification
REQ-032 Load pattern 0xFF, start 0x10; drive 20 back-to-back beats 0x10..0x23 -> ready_o high every cycle, beat_cnt_o=20, err_cnt_o=0, last_data_o=0x23.
REQ-033 Load pattern 0x55; hold valid_i high with an incrementing source -> ready_o toggles 1,0,1,0; beats accepted every other cycle only; no errors.
REQ-034 Start 0x00; send 0x00, 0x01, 0x05, 0x06 -> err_o pulses once after 0x05, err_cnt_o=1, and 0x06 is accepted without error.
REQ-035 Pattern 0xFE; drive valid_i=1 with data 0xAA, then change data to 0xAB while ready_o=0 -> proto_err_o=1 and stays high; a later cfg_load_i clears it.
REQ-036 Start 0xFE; send 0xFE, 0xFF, 0x00 -> no error, confirming wrap. Then assert cfg_load_i in the same cycle as a transfer -> beat_cnt_o=0 afterwards.
REQ-037 Assert rst mid-stream -> all outputs return to their reset values at the next edge and ready_o stays 0 until cfg_load_i.

Source files
------------

// File: rtl/handshake_sink_if.sv
// rtl/handshake_sink_if.sv - valid/ready beat channel between an upstream source and the sink
interface handshake_sink_if;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;

    // Upstream side: offers beats and observes backpressure.
    modport master (
        output valid_i,
        output data_i,
        input  ready_o
    );

    // Sink side: consumes beats and drives backpressure.
    modport slave (
        input  valid_i,
        input  data_i,
        output ready_o
    );
endinterface

// File: rtl/handshake_sink.sv
// rtl/handshake_sink.sv - patterned-backpressure sink with sequence checker and handshake monitor
module handshake_sink (
    input  logic                    clk,
    input  logic                    rst,
    handshake_sink_if.slave         hs,
    input  logic                    cfg_load_i,
    input  logic [7:0]              cfg_pattern_i,
    input  logic [7:0]              cfg_start_i,
    output logic [15:0]             beat_cnt_o,
    output logic [7:0]              err_cnt_o,
    output logic                    err_o,
    output logic                    proto_err_o,
    output logic [7:0]              last_data_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pat_q;
    logic [7:0] exp_q;
    logic       hold_q;
    logic [7:0] hold_data_q;
    logic       ready;
    logic       xfer;
    logic       mismatch;

    // Ready comes purely from registers so upstream sees no combinational loop.
    assign ready    = (state_q == RUN) && pat_q[0];
    assign hs.ready_o = ready;

    // A load in the same cycle as a handshake swallows the beat.
    assign xfer     = hs.valid_i && ready && !cfg_load_i;
    assign mismatch = (hs.data_i != exp_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any load enters (or restarts) RUN; only reset leaves it.
    always_comb begin
        state_d = state_q;
        if (cfg_load_i) begin
            state_d = RUN;
        end
    end

    // Pattern rotation, sequence checking, counters and handshake monitor.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q       <= 8'h00;
            exp_q       <= 8'h00;
            beat_cnt_o  <= 16'h0000;
            err_cnt_o   <= 8'h00;
            last_data_o <= 8'h00;
            err_o       <= 1'b0;
            proto_err_o <= 1'b0;
            hold_q      <= 1'b0;
            hold_data_q <= 8'h00;
        end else if (cfg_load_i) begin
            pat_q       <= cfg_pattern_i;
            exp_q       <= cfg_start_i;
            beat_cnt_o  <= 16'h0000;
            err_cnt_o   <= 8'h00;
            err_o       <= 1'b0;
            proto_err_o <= 1'b0;
            // Restart the monitor so a stall from before the load is not judged.
            hold_q      <= 1'b0;
            hold_data_q <= 8'h00;
        end else if (state_q == RUN) begin
            pat_q <= {pat_q[0], pat_q[7:1]};
            err_o <= xfer && mismatch;
            if (xfer) begin
                beat_cnt_o  <= beat_cnt_o + 16'd1;
                last_data_o <= hs.data_i;
                if (mismatch) begin
                    exp_q <= hs.data_i + 8'd1;
                    if (err_cnt_o != 8'hFF) begin
                        err_cnt_o <= err_cnt_o + 8'd1;
                    end
                end else begin
                    exp_q <= exp_q + 8'd1;
                end
            end
            // A stalled beat must be re-offered unchanged in the next cycle.
            hold_q      <= hs.valid_i && !ready;
            hold_data_q <= hs.data_i;
            if (hold_q && (!hs.valid_i || (hs.data_i != hold_data_q))) begin
                proto_err_o <= 1'b1;
            end
        end else begin
            err_o  <= 1'b0;
            hold_q <= 1'b0;
        end
    end

endmodule
